// File: rtl/test_ctrl.sv
// Test-harness controller: HALT/signature/cycle registers on the CPU data bus,
// and a signature dump that streams RAM words [SIG_BEGIN, SIG_END) after a halt.
`timescale 1ns/1ps
module test_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = XLEN'(32'h2000_0000),
    parameter int unsigned     TIMEOUT   = 32'd0
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            store_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] address_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] reg_rdata_o,
    output logic            reg_hit_o,
    output logic            mem_rd_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            dump_valid_o,
    input  logic            dump_ready_i,
    output logic [XLEN-1:0] dump_data_o,
    output logic            dump_last_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            timed_out_o,
    output logic [XLEN-2:0] exit_code_o
);

    localparam int unsigned     W         = XLEN / 8;
    localparam int unsigned     WB        = $clog2(W);
    localparam logic [XLEN-1:0] W_BYTES   = XLEN'(W);
    localparam logic [XLEN-1:0] WIN_BYTES = XLEN'(4 * W);
    localparam logic [XLEN-1:0] ONE       = {{(XLEN-1){1'b0}}, 1'b1};
    localparam bit              TO_EN     = (TIMEOUT != 32'd0);
    localparam logic [XLEN-1:0] TO_LIM    = XLEN'(TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   sig_begin_q;
    logic [XLEN-1:0]   sig_end_q;
    logic [XLEN-1:0]   cycle_q;
    logic [XLEN-1:0]   ptr_q;
    logic [XLEN-2:0]   exit_code_q;
    logic [XLEN-1:0]   dump_data_q;
    logic              done_q;
    logic              pass_q;
    logic              timed_out_q;
    logic              dump_valid_q;
    logic              dump_last_q;
    logic              mem_rd_q;

    logic [XLEN-1:0]   off_s;
    logic              in_win_s;
    logic              aligned_s;
    logic [1:0]        sel_s;
    logic              hit_halt_s;
    logic              hit_begin_s;
    logic              hit_end_s;
    logic              halt_go_s;
    logic              timeout_s;
    logic [XLEN-1:0]   ptr_inc_d;
    logic [XLEN-1:0]   cycle_inc_d;
    logic              last_d;

    // Unsigned offset makes addresses below BASE_ADDR wrap far outside the window.
    assign off_s       = address_i - BASE_ADDR;
    assign in_win_s    = (off_s < WIN_BYTES);
    assign aligned_s   = (off_s[WB-1:0] == '0);
    assign sel_s       = off_s[WB+1:WB];
    assign hit_halt_s  = in_win_s && aligned_s && (sel_s == 2'd0);
    assign hit_begin_s = in_win_s && aligned_s && (sel_s == 2'd1);
    assign hit_end_s   = in_win_s && aligned_s && (sel_s == 2'd2);
    assign halt_go_s   = (state_q == S_RUN) && store_i && hit_halt_s && store_data_i[0];
    assign timeout_s   = TO_EN && (cycle_q == TO_LIM);
    assign ptr_inc_d   = ptr_q + W_BYTES;
    assign cycle_inc_d = (cycle_q == '1) ? cycle_q : (cycle_q + ONE);
    assign last_d      = (ptr_inc_d >= sig_end_q);

    assign reg_hit_o    = load_i && in_win_s;
    assign mem_rd_o     = mem_rd_q;
    assign mem_addr_o   = ptr_q;
    assign dump_valid_o = dump_valid_q;
    assign dump_data_o  = dump_data_q;
    assign dump_last_o  = dump_last_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timed_out_o  = timed_out_q;
    assign exit_code_o  = exit_code_q;

    // Register read mux; HALT, unaligned and out-of-window addresses read as zero.
    always_comb begin
        reg_rdata_o = '0;
        if (in_win_s && aligned_s) begin
            case (sel_s)
                2'd1:    reg_rdata_o = sig_begin_q;
                2'd2:    reg_rdata_o = sig_end_q;
                2'd3:    reg_rdata_o = cycle_q;
                default: reg_rdata_o = '0;
            endcase
        end else begin
            reg_rdata_o = '0;
        end
    end

    // Controller FSM with registers and registered stream/status outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_RUN;
            sig_begin_q  <= '0;
            sig_end_q    <= '0;
            cycle_q      <= '0;
            ptr_q        <= '0;
            exit_code_q  <= '0;
            dump_data_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            mem_rd_q     <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (store_i && hit_begin_s) begin
                        sig_begin_q <= {store_data_i[XLEN-1:WB], {WB{1'b0}}};
                    end
                    if (store_i && hit_end_s) begin
                        sig_end_q <= {store_data_i[XLEN-1:WB], {WB{1'b0}}};
                    end
                    // A halt in the timeout cycle takes priority; CYCLE freezes on exit.
                    if (halt_go_s) begin
                        exit_code_q <= store_data_i[XLEN-1:1];
                        ptr_q       <= sig_begin_q;
                        if (sig_end_q <= sig_begin_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (store_data_i[XLEN-1:1] == '0);
                        end else begin
                            state_q  <= S_RD;
                            mem_rd_q <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        state_q     <= S_DONE;
                        timed_out_q <= 1'b1;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                    end else begin
                        cycle_q <= cycle_inc_d;
                    end
                end
                S_RD: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= S_WT;
                end
                S_WT: begin
                    dump_data_q  <= mem_data_i;
                    dump_valid_q <= 1'b1;
                    dump_last_q  <= last_d;
                    state_q      <= S_SEND;
                end
                S_SEND: begin
                    if (dump_ready_i) begin
                        ptr_q        <= ptr_inc_d;
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                        if (dump_last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            pass_q  <= (exit_code_q == '0) && !timed_out_q;
                        end else begin
                            state_q  <= S_RD;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_ctrl.sv
// Directed bench for test_ctrl: a queue-based expectation of the signature stream
// plus a RAM responder, checked every cycle, with literal checks on each scenario.
`timescale 1ns/1ps
module tb_test_ctrl;

    localparam logic [31:0] BASE   = 32'h2000_0000;
    localparam logic [31:0] A_HALT = BASE;
    localparam logic [31:0] A_BEG  = BASE + 32'd4;
    localparam logic [31:0] A_END  = BASE + 32'd8;
    localparam logic [31:0] A_CYC  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        store = 1'b0;
    logic        load = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] reg_rdata;
    logic        reg_hit;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'd0;
    logic        dump_valid;
    logic        ready = 1'b0;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [30:0] exit_code;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_addr = 32'd0;
    logic        held = 1'b0;
    logic [31:0] held_data = 32'd0;
    logic [31:0] exp_data_q[$];
    logic        exp_last_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_q[$];
    int          last_cnt = 0;
    int          last_idx = 0;

    test_ctrl #(.XLEN(32), .BASE_ADDR(BASE), .TIMEOUT(32'd50)) u_dut (
        .clock_i(clk), .reset_i(reset), .store_i(store), .load_i(load),
        .address_i(address), .store_data_i(store_data),
        .reg_rdata_o(reg_rdata), .reg_hit_o(reg_hit),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .dump_valid_o(dump_valid), .dump_ready_i(ready), .dump_data_o(dump_data),
        .dump_last_o(dump_last), .done_o(done), .pass_o(pass),
        .timed_out_o(timed_out), .exit_code_o(exit_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_000A;
            32'h104: return 32'h0000_000B;
            32'h108: return 32'h0000_000C;
            default: return {16'hCAFE, a[15:0]};
        endcase
    endfunction

    // Expected stream: one word per aligned address in [b, e), last on the final one.
    task automatic plan_dump(input logic [31:0] b, input logic [31:0] e);
        for (logic [31:0] p = b; p < e; p += 32'd4) begin
            exp_addr_q.push_back(p);
            exp_data_q.push_back(ram_word(p));
            exp_last_q.push_back((p + 32'd4) >= e);
        end
    endtask

    // RAM responder (data valid only the cycle after mem_rd) and ready pattern.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            rd_pend  = 1'b0;
            mem_data = 32'hDEAD_BEEF;
        end else begin
            mem_data = rd_pend ? ram_word(rd_addr) : 32'hDEAD_BEEF;
            rd_pend  = mem_rd;
            rd_addr  = mem_addr;
        end
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = ~ready;
        endcase
    end

    // Per-cycle compare against the expected read addresses and stream words.
    always @(negedge clk) begin
        if (reset) begin
            exp_data_q.delete();
            exp_last_q.delete();
            exp_addr_q.delete();
            held = 1'b0;
        end else begin
            if (!done) chk("pass_without_done", pass, 1'b0);
            if (mem_rd) begin
                if (exp_addr_q.size() > 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
                else chk("unexpected_mem_rd", mem_rd, 1'b0);
            end
            if (dump_valid) begin
                if (held) chk("data_stable", dump_data, held_data);
                if (ready) begin
                    if (exp_data_q.size() > 0) begin
                        chk("dump_data", dump_data, exp_data_q.pop_front());
                        chk("dump_last", dump_last, exp_last_q.pop_front());
                        got_q.push_back(dump_data);
                        if (dump_last) begin
                            last_cnt++;
                            last_idx = got_q.size();
                        end
                    end else begin
                        chk("unexpected_word", dump_valid, 1'b0);
                    end
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = dump_data;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        store = 1'b0;
        load  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
        last_cnt = 0;
        last_idx = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        address = a; store_data = d; store = 1'b1;
        @(posedge clk);
        #1;
        store = 1'b0; address = 32'd0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d, output logic hit);
        load = 1'b1; address = a;
        #1;
        d = reg_rdata; hit = reg_hit;
        load = 1'b0; address = 32'd0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic check_abc(input string tag);
        chk({tag, "_word_count"}, got_q.size(), 3);
        while (got_q.size() < 3) got_q.push_back(32'hFFFF_FFFF);
        chk({tag, "_w0"}, got_q[0], 32'h0000_000A);
        chk({tag, "_w1"}, got_q[1], 32'h0000_000B);
        chk({tag, "_w2"}, got_q[2], 32'h0000_000C);
        chk({tag, "_last_count"}, last_cnt, 1);
        chk({tag, "_last_on_third"}, last_idx, 3);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_pass"}, pass, 1'b1);
        chk({tag, "_timed_out"}, timed_out, 1'b0);
        chk({tag, "_exit_code"}, exit_code, 31'd0);
        chk({tag, "_words_left"}, exp_data_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c1, c2;
        logic        h;
        int          n;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_timed_out", timed_out, 1'b0);
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_dump_last", dump_last, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_exit_code", exit_code, 31'd0);
        rd_reg(A_CYC, d, h);
        chk("rst_cycle", d, 32'd0);

        // Three-word dump with ready always high
        reset_dut();
        ready_mode = 1;
        do_store(A_BEG, 32'h100);
        do_store(A_END, 32'h10C);
        plan_dump(32'h100, 32'h10C);
        do_store(A_HALT, 32'd1);
        wait_done(100, n);
        check_abc("s1");
        chk("s1_valid_after_done", dump_valid, 1'b0);

        // Same dump with ready toggling every cycle
        reset_dut();
        ready_mode = 2;
        do_store(A_BEG, 32'h100);
        do_store(A_END, 32'h10C);
        plan_dump(32'h100, 32'h10C);
        do_store(A_HALT, 32'd1);
        wait_done(100, n);
        check_abc("s2");

        // Empty signature region with non-zero exit code
        reset_dut();
        ready_mode = 1;
        do_store(A_BEG, 32'h200);
        do_store(A_END, 32'h200);
        rd_reg(A_HALT, d, h);
        chk("s3_halt_reads_zero", d, 32'd0);
        chk("s3_halt_hit", h, 1'b1);
        do_store(A_HALT, 32'h7);
        wait_done(5, n);
        chk("s3_done", done, 1'b1);
        chk("s3_pass", pass, 1'b0);
        chk("s3_exit_code", exit_code, 31'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("s3_no_words", got_q.size(), 0);

        // Alignment, misses, and ignored HALT with bit0 clear
        reset_dut();
        do_store(A_BEG, 32'h103);
        rd_reg(A_BEG, d, h);
        chk("s4_begin_aligned", d, 32'h100);
        chk("s4_begin_hit", h, 1'b1);
        do_store(A_END, 32'h10F);
        rd_reg(A_END, d, h);
        chk("s4_end_aligned", d, 32'h10C);
        rd_reg(BASE + 32'd16, d, h);
        chk("s4_miss_above_hit", h, 1'b0);
        chk("s4_miss_above_data", d, 32'd0);
        rd_reg(BASE - 32'd4, d, h);
        chk("s4_miss_below_hit", h, 1'b0);
        do_store(A_HALT, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("s4_not_done", done, 1'b0);
        rd_reg(A_CYC, c1, h);
        @(posedge clk);
        #1;
        rd_reg(A_CYC, c2, h);
        chk("s4_cycle_runs", c2, c1 + 32'd1);

        // Timeout with no halt
        reset_dut();
        wait_done(100, n);
        chk("s5_cycles_to_done", n, 50);
        chk("s5_done", done, 1'b1);
        chk("s5_timed_out", timed_out, 1'b1);
        chk("s5_pass", pass, 1'b0);
        rd_reg(A_CYC, d, h);
        chk("s5_cycle", d, 32'd49);
        do_store(A_BEG, 32'h400);
        rd_reg(A_BEG, d, h);
        chk("s5_store_ignored", d, 32'd0);
        do_store(A_HALT, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rd_reg(A_CYC, d, h);
        chk("s5_cycle_frozen", d, 32'd49);
        chk("s5_no_words", got_q.size(), 0);

        // Halt store in the timeout cycle: halt wins
        reset_dut();
        ready_mode = 1;
        do_store(A_BEG, 32'h300);
        do_store(A_END, 32'h304);
        plan_dump(32'h300, 32'h304);
        load = 1'b1; address = A_CYC;
        #1;
        n = 0;
        while (reg_rdata != 32'd49 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s6_reach_49", reg_rdata, 32'd49);
        load = 1'b0;
        do_store(A_HALT, 32'd1);
        wait_done(100, n);
        chk("s6_timed_out", timed_out, 1'b0);
        chk("s6_pass", pass, 1'b1);
        chk("s6_word_count", got_q.size(), 1);
        if (got_q.size() == 0) got_q.push_back(32'hFFFF_FFFF);
        chk("s6_word", got_q[0], 32'hCAFE_0300);
        chk("s6_last_count", last_cnt, 1);

        // Reset while stalled in the second SEND
        reset_dut();
        ready_mode = 1;
        do_store(A_BEG, 32'h100);
        do_store(A_END, 32'h10C);
        plan_dump(32'h100, 32'h10C);
        do_store(A_HALT, 32'd1);
        n = 0;
        while (got_q.size() < 1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        ready_mode = 0;
        n = 0;
        while (!(dump_valid && !ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s7_in_second_send", dump_valid, 1'b1);
        chk("s7_one_word_before", got_q.size(), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("s7_dump_valid", dump_valid, 1'b0);
        chk("s7_dump_last", dump_last, 1'b0);
        chk("s7_dump_data", dump_data, 32'd0);
        chk("s7_mem_rd", mem_rd, 1'b0);
        chk("s7_done", done, 1'b0);
        chk("s7_pass", pass, 1'b0);
        chk("s7_exit_code", exit_code, 31'd0);
        reset = 1'b0;
        ready_mode = 1;
        rd_reg(A_BEG, d, h);
        chk("s7_begin_cleared", d, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rd_reg(A_CYC, d, h);
        chk("s7_running_again", d, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        chk("s7_no_more_words", got_q.size(), 1);
        chk("s7_not_done", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_ctrl.md
TEST_CTRL -- requirements
Module: test_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data and address width; legal values are 32 and 64.
REQ-002 Parameter BASE_ADDR, default 32'h20000000, byte address of the HALT register.
REQ-003 Parameter TIMEOUT, default 0, cycle limit before a forced stop; 0 disables the limit.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 store  input  1  CPU store strobe, valid for one cycle per access.
REQ-007 load  input  1  CPU load strobe.
REQ-008 address  input  XLEN  CPU data byte address.
REQ-009 store_data  input  XLEN  CPU store data.
REQ-010 reg_rdata  output  XLEN  register read data, combinational from address.
REQ-011 reg_hit  output  1  asserted when load=1 and address is inside the register window.
REQ-012 mem_rd  output  1  read strobe to the RAM read port.
REQ-013 mem_addr  output  XLEN  word-aligned byte address to the RAM read port.
REQ-014 mem_data  input  XLEN  RAM read data, valid exactly 1 cycle after mem_rd.
REQ-015 dump_valid / dump_ready / dump_data[XLEN] / dump_last  out/in/out/out  signature stream; dump_last marks the final word.
REQ-016 done  output  1  sticky; run finished (halt or timeout) and dump complete.
REQ-017 pass  output  1  valid while done=1.
REQ-018 timed_out  output  1  sticky timeout flag.
REQ-019 exit_code  output  XLEN-1  halt code latched from store_data[XLEN-1:1].

Function
REQ-020 Register map, W = XLEN/8: HALT at BASE_ADDR, SIG_BEGIN at BASE_ADDR+W, SIG_END at BASE_ADDR+2W, CYCLE at BASE_ADDR+3W (read-only); stores to any other address are ignored.
REQ-021 SIG_BEGIN and SIG_END shall store byte addresses with bits [log2(W)-1:0] forced to 0.
REQ-022 reg_rdata shall return SIG_BEGIN, SIG_END or CYCLE for the matching address, and 0 for HALT or a miss.
REQ-023 CYCLE shall increment by 1 every cycle in RUN, saturate at all-ones, and freeze on leaving RUN.
REQ-024 FSM states: RUN, RD, WT, SEND, DONE; reset enters RUN.
REQ-025 RUN -> RD on a store to HALT with store_data[0]=1: latch exit_code, set pointer = SIG_BEGIN; a HALT store with bit0=0 is ignored.
REQ-026 In RUN, if SIG_END <= SIG_BEGIN at halt time, go directly to DONE with no stream words.
REQ-027 RD: mem_rd=1 and mem_addr=pointer for one cycle, then go to WT.
REQ-028 WT: capture mem_data into dump_data, then go to SEND.
REQ-029 SEND: hold dump_valid=1 with dump_data stable until dump_ready=1; on the handshake, pointer += W.
REQ-030 SEND: dump_last=1 when pointer+W >= SIG_END; after that handshake go to DONE, otherwise go to RD.
REQ-031 DONE is terminal until reset; done=1; pass=1 iff exit_code==0 and timed_out=0.
REQ-032 Once the FSM leaves RUN, all register stores are ignored.
REQ-033 Timeout: TIMEOUT!=0 and CYCLE reaches TIMEOUT-1 in RUN without a halt -> set timed_out=1, go to DONE with no dump, pass=0.
REQ-034 If a halt store and timeout occur in the same cycle, the halt wins.
REQ-035 The pointer shall be XLEN bits wide and wrap modulo 2^XLEN; the loop ends only through the REQ-030 compare.

Reset
REQ-036 Reset shall clear SIG_BEGIN, SIG_END, CYCLE, pointer, exit_code, done, pass, timed_out, dump_valid, dump_last, mem_rd and dump_data to 0, and set the state to RUN.
REQ-037 Reset asserted in any state, including mid-stream, shall abort within the same edge; no further stream words are produced.

Verification
REQ-038 Store SIG_BEGIN=0x100, SIG_END=0x10C, HALT=1; RAM words 0xA,0xB,0xC; dump_ready=1 -> exactly 3 words A,B,C, dump_last on C, done=1, pass=1.
REQ-039 Same setup with dump_ready toggling 0/1 every cycle -> the same 3 words in order, dump_data stable while valid=1 and ready=0.
REQ-040 Store HALT=0x7 (code 3) with SIG_END=SIG_BEGIN=0x200 -> no dump_valid, done=1, pass=0, exit_code=3.
REQ-041 TIMEOUT=50, no halt store -> timed_out=1 and done=1 after 50 cycles, pass=0, CYCLE reads 49.
REQ-042 Store SIG_BEGIN=0x103 -> reads back 0x100; store HALT=0 -> FSM stays in RUN.
REQ-043 Reset during the second SEND of REQ-038 -> all outputs at reset values on the next cycle, state RUN.
